// File: rtl/iic_master_seq.sv
// Byte-level IIC master sequencer: one register read/write command becomes a complete
// START/address/register/data/STOP bit sequence on an open-drain-emulated pad interface.

module iic_master_seq #(
    parameter bit          MD_SIM_ABLE = 1'b0,
    parameter int unsigned NB_CLK_DIV  = 250,
    parameter int unsigned WD_ERR_INFO = 4
) (
    input  logic                   sys_clk,
    input  logic                   sys_resetn,
    input  logic                   s_cmd_valid,
    output logic                   s_cmd_ready,
    input  logic                   s_cmd_rw,
    input  logic [6:0]             s_cmd_dev,
    input  logic [7:0]             s_cmd_reg,
    input  logic [7:0]             s_cmd_wdat,
    output logic                   m_rsp_valid,
    output logic [7:0]             m_rsp_rdat,
    output logic                   m_rsp_err,
    output logic                   m_iic_src_csn,
    output logic                   m_iic_src_scl,
    output logic                   m_iic_src_sdo,
    output logic                   m_iic_src_tri,
    input  logic                   m_iic_src_sdi,
    output logic [WD_ERR_INFO-1:0] m_err_iic_info1
);

    localparam int unsigned QDiv  = MD_SIM_ABLE ? 2 : NB_CLK_DIV;
    localparam logic [15:0] QLast = 16'(QDiv - 1);

    typedef enum logic [3:0] {
        StIdle, StStart, StTxb, StRack, StRstart, StRxb, StTack, StStop, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  slot_q, slot_d;
    logic        rw_q, rw_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  wdat_q, wdat_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  rdat_q, rdat_d;
    logic [3:0]  info_q, info_d;

    logic       qtr_end, slot_end, sample;
    logic [1:0] nack_idx;
    logic [7:0] tx_byte;
    logic       sda, rel;

    assign qtr_end  = (div_q == QLast);
    assign slot_end = qtr_end && (qtr_q == 2'd3);
    // SDA is sampled on the last cycle of q2, just before SCL's high phase is half over.
    assign sample   = qtr_end && (qtr_q == 2'd2);
    assign nack_idx = (slot_q == 2'd2 && rw_q) ? 2'd3 : slot_q;

    always_comb begin
        unique case (slot_q)
            2'd0:    tx_byte = {dev_q, 1'b0};
            2'd1:    tx_byte = reg_q;
            default: tx_byte = rw_q ? {dev_q, 1'b1} : wdat_q;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_resetn) begin
            state_q <= StIdle;
            div_q   <= '0;
            qtr_q   <= '0;
            bit_q   <= '0;
            slot_q  <= '0;
            rw_q    <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            wdat_q  <= '0;
            rx_q    <= '0;
            rdat_q  <= '0;
            info_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            slot_q  <= slot_d;
            rw_q    <= rw_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wdat_q  <= wdat_d;
            rx_q    <= rx_d;
            rdat_q  <= rdat_d;
            info_q  <= info_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        slot_d  = slot_q;
        rw_d    = rw_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        wdat_d  = wdat_q;
        rx_d    = rx_q;
        rdat_d  = rdat_q;
        info_d  = info_q;
        if (state_q != StIdle && state_q != StDone) begin
            div_d = qtr_end ? 16'd0 : div_q + 16'd1;
            if (qtr_end) qtr_d = qtr_q + 2'd1;
        end
        unique case (state_q)
            StIdle: begin
                if (s_cmd_valid) begin
                    rw_d    = s_cmd_rw;
                    dev_d   = s_cmd_dev;
                    reg_d   = s_cmd_reg;
                    wdat_d  = s_cmd_wdat;
                    info_d  = '0;
                    div_d   = '0;
                    qtr_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (slot_end) begin
                    slot_d  = 2'd0;
                    bit_d   = 3'd7;
                    state_d = StTxb;
                end
            end
            StTxb: begin
                if (slot_end) begin
                    if (bit_q == 3'd0) state_d = StRack;
                    else               bit_d   = bit_q - 3'd1;
                end
            end
            StRack: begin
                if (sample && m_iic_src_sdi) info_d[nack_idx] = 1'b1;
                if (slot_end) begin
                    bit_d = 3'd7;
                    // A NACK is already latched in info_q by the time the slot ends.
                    if (|info_q) begin
                        state_d = StStop;
                    end else if (slot_q == 2'd0) begin
                        slot_d  = 2'd1;
                        state_d = StTxb;
                    end else if (slot_q == 2'd1) begin
                        slot_d  = 2'd2;
                        state_d = rw_q ? StRstart : StTxb;
                    end else begin
                        state_d = rw_q ? StRxb : StStop;
                    end
                end
            end
            StRstart: begin
                if (slot_end) begin
                    bit_d   = 3'd7;
                    state_d = StTxb;
                end
            end
            StRxb: begin
                if (sample) rx_d = {rx_q[6:0], m_iic_src_sdi};
                if (slot_end) begin
                    if (bit_q == 3'd0) state_d = StTack;
                    else               bit_d   = bit_q - 3'd1;
                end
            end
            StTack: begin
                if (slot_end) state_d = StStop;
            end
            StStop: begin
                if (slot_end) begin
                    if (rw_q && !(|info_q)) rdat_d = rx_q;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_iic_src_scl = 1'b1;
        m_iic_src_csn = 1'b0;
        sda           = 1'b1;
        rel           = 1'b0;
        unique case (state_q)
            StStart: begin
                m_iic_src_scl = (qtr_q != 2'd3);
                sda           = ~qtr_q[1];
            end
            StTxb: begin
                m_iic_src_scl = qtr_q[1];
                sda           = tx_byte[bit_q];
            end
            StRack, StRxb, StTack: begin
                m_iic_src_scl = qtr_q[1];
                rel           = 1'b1;
            end
            StRstart: begin
                m_iic_src_scl = (qtr_q != 2'd0);
                sda           = ~qtr_q[1];
            end
            StStop: begin
                m_iic_src_scl = (qtr_q != 2'd0);
                sda           = (qtr_q == 2'd3);
            end
            default: m_iic_src_csn = 1'b1;
        endcase
        // Open-drain emulation: a logic 1 is expressed by releasing the line.
        m_iic_src_tri = rel | sda;
        m_iic_src_sdo = rel | sda;
    end

    always_comb begin
        m_err_iic_info1      = '0;
        m_err_iic_info1[3:0] = info_q;
    end

    assign s_cmd_ready = (state_q == StIdle);
    assign m_rsp_valid = (state_q == StDone);
    assign m_rsp_err   = m_rsp_valid & (|info_q);
    assign m_rsp_rdat  = rdat_q;

endmodule
